// File: rtl/csr_file_m_if.sv
// csr_file_m_if: decoder/trap/PC-select bundle for the machine-mode CSR unit.
//   master : decoder side; drives the CSR instruction fields, retire/trap/mret,
//            and receives rd_val, illegal, mtvec_o, mepc_o, mie_o.
//   slave  : the CSR unit itself.
interface csr_file_m_if;
  logic        csr_en;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [4:0]  rs1_field;
  logic [31:0] rs1_val;
  logic [31:0] rd_val;
  logic        illegal;
  logic        instr_retire;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] trap_val;
  logic        mret;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        mie_o;

  modport master (
    output csr_en, funct3, csr_addr, rs1_field, rs1_val, instr_retire,
           trap, trap_pc, trap_cause, trap_val, mret,
    input  rd_val, illegal, mtvec_o, mepc_o, mie_o
  );

  modport slave (
    input  csr_en, funct3, csr_addr, rs1_field, rs1_val, instr_retire,
           trap, trap_pc, trap_cause, trap_val, mret,
    output rd_val, illegal, mtvec_o, mepc_o, mie_o
  );
endinterface

// File: rtl/csr_file_m.sv
// csr_file_m: machine-mode CSR unit for the single-cycle RV32 core.
// Implements the architected M-mode CSRs with read-modify-write semantics
// (CSRRW/S/C and immediate forms), illegal-access detection, trap entry and
// MRET state updates. Optional 64-bit cycle/instret counters are built only
// when the macro CSR_COUNTERS_EN is defined.
// Ports:
//   i_clk    : clock
//   i_reset  : synchronous, active-high reset
//   s_bus    : csr_file_m_if.slave -- CSR instruction fields in, old value /
//              illegal flag out (combinational), trap/mret/retire events in,
//              mtvec_o/mepc_o/mie_o out to the PC-select logic.
module csr_file_m #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned HARTID      = 0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic         i_clk,
  input  logic         i_reset,
  csr_file_m_if.slave  s_bus
);

  logic            r_mie;
  logic            r_mpie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;

  logic [XLEN-1:0] w_op;
  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_new;
  logic            w_impl;
  logic            w_write_try;
  logic            w_illegal;
  logic            w_we;

`ifdef CSR_COUNTERS_EN
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;
  logic [63:0] w_mcycle_d;
  logic [63:0] w_minstret_d;
`else
  logic        w_unused_retire;
  assign w_unused_retire = s_bus.instr_retire;
`endif

  // Immediate forms (funct3[2]=1) take the zero-extended rs1 field as operand.
  assign w_op = s_bus.funct3[2] ? {{(XLEN-5){1'b0}}, s_bus.rs1_field} : s_bus.rs1_val;

  // Read mux; also flags whether the address is implemented.
  always_comb begin
    w_old  = '0;
    w_impl = 1'b1;
    case (s_bus.csr_addr)
      12'h300: w_old = {24'b0, r_mpie, 3'b0, r_mie, 3'b0};
      12'h305: w_old = r_mtvec;
      12'h340: w_old = r_mscratch;
      12'h341: w_old = r_mepc;
      12'h342: w_old = r_mcause;
      12'h343: w_old = r_mtval;
      12'hF14: w_old = XLEN'(HARTID);
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: w_old = r_mcycle[31:0];
      12'hB80, 12'hC80: w_old = r_mcycle[63:32];
      12'hB02, 12'hC02: w_old = r_minstret[31:0];
      12'hB82, 12'hC82: w_old = r_minstret[63:32];
`endif
      default: w_impl = 1'b0;
    endcase
  end

  // RS/RC with rs1_field==0 are pure reads, so they may target read-only CSRs.
  assign w_write_try = (s_bus.funct3[1:0] == 2'b01) || (s_bus.rs1_field != 5'd0);

  assign w_illegal = s_bus.csr_en &&
                     ((s_bus.funct3[1:0] == 2'b00) || !w_impl ||
                      (w_write_try && (s_bus.csr_addr[11:10] == 2'b11)));

  // A trap in the same cycle drops the CSR write.
  assign w_we = s_bus.csr_en && !w_illegal && w_write_try && !s_bus.trap;

  always_comb begin
    w_new = w_old;
    case (s_bus.funct3[1:0])
      2'b01:   w_new = w_op;
      2'b10:   w_new = w_old | w_op;
      2'b11:   w_new = w_old & ~w_op;
      default: w_new = w_old;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtvec    <= MTVEC_RESET & ~32'h3;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else begin
      if (w_we) begin
        case (s_bus.csr_addr)
          12'h300: begin
            r_mie  <= w_new[3];
            r_mpie <= w_new[7];
          end
          12'h305: r_mtvec    <= {w_new[XLEN-1:2], 2'b00};
          12'h340: r_mscratch <= w_new;
          12'h341: r_mepc     <= {w_new[XLEN-1:2], 2'b00};
          12'h342: r_mcause   <= w_new;
          12'h343: r_mtval    <= w_new;
          default: ;
        endcase
      end
      // Trap beats MRET; both override an mstatus write in the same cycle.
      if (s_bus.trap) begin
        r_mepc   <= {s_bus.trap_pc[XLEN-1:2], 2'b00};
        r_mcause <= s_bus.trap_cause;
        r_mtval  <= s_bus.trap_val;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else if (s_bus.mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  // A write to either half replaces that half and freezes the other (no carry).
  always_comb begin
    w_mcycle_d   = r_mcycle + 64'd1;
    w_minstret_d = r_minstret + {63'b0, s_bus.instr_retire};
    if (w_we && (s_bus.csr_addr == 12'hB00)) begin
      w_mcycle_d = {r_mcycle[63:32], w_new};
    end else if (w_we && (s_bus.csr_addr == 12'hB80)) begin
      w_mcycle_d = {w_new, r_mcycle[31:0]};
    end
    if (w_we && (s_bus.csr_addr == 12'hB02)) begin
      w_minstret_d = {r_minstret[63:32], w_new};
    end else if (w_we && (s_bus.csr_addr == 12'hB82)) begin
      w_minstret_d = {w_new, r_minstret[31:0]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      r_mcycle   <= w_mcycle_d;
      r_minstret <= w_minstret_d;
    end
  end
`endif

  assign s_bus.rd_val  = w_old;
  assign s_bus.illegal = w_illegal;
  assign s_bus.mtvec_o = r_mtvec;
  assign s_bus.mepc_o  = r_mepc;
  assign s_bus.mie_o   = r_mie;

endmodule

// File: doc/csr_file_m.md
Name: csr_file_m

Overview:
- Machine-mode CSR unit for the single-cycle RV32 core; successor to the flat CSR register array.
- Implements only the architected CSRs, with true read-modify-write semantics for CSRRW/S/C and the immediate forms.
- Adds illegal-access detection, 64-bit cycle/instret counters, and trap entry/MRET state updates.
- Sits beside the register file; the decoder drives it and the PC-select logic consumes mtvec/mepc.

Parameters:
- XLEN, 32: data width; only 32 is supported.
- HARTID, 0: value returned by mhartid.
- MTVEC_RESET, 32'h0000_0000: reset value of mtvec; bits[1:0] are ignored.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- csr_en  in  1  CSR instruction in the current cycle
- funct3  in  3  instr[14:12]
- csr_addr  in  12  instr[31:20]
- rs1_field  in  5  instr[19:15]; rs1 index, or zimm for the immediate forms
- rs1_val  in  32  register rs1 value
- rd_val  out  32  old CSR value (combinational)
- illegal  out  1  illegal CSR access (combinational)
- instr_retire  in  1  an instruction retires this cycle
- trap  in  1  take a trap this cycle
- trap_pc  in  32  PC of the faulting instruction
- trap_cause  in  32  mcause value
- trap_val  in  32  mtval value
- mret  in  1  MRET executes this cycle
- mtvec_o  out  32  trap vector, bits[1:0]=0
- mepc_o  out  32  return PC
- mie_o  out  1  mstatus.MIE

Behaviour:
- Implemented addresses:
  - mstatus 0x300: only MIE[3] and MPIE[7] are stored; all other bits read 0.
  - mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
  - cycle/cycleh 0xC00/0xC80, instret/instreth 0xC02/0xC82: read-only shadows.
  - mhartid 0xF14: read-only, returns HARTID.
- Any other address reads 0 and is illegal when csr_en=1.
- Operand: funct3[2]=1 uses zero-extended rs1_field; funct3[2]=0 uses rs1_val.
- New value:
  - RW (x01): operand.
  - RS (x10): old | operand.
  - RC (x11): old & ~operand.
- Write attempt:
  - RW always attempts a write.
  - RS/RC attempt a write only when rs1_field != 0.
- illegal=1 when csr_en=1 and any of:
  - funct3 is 000 or 100;
  - address is unimplemented;
  - a write is attempted to addr[11:10]==2'b11.
- When illegal=1: no state change, but rd_val still shows the read value.
- Reads are combinational in the same cycle; writes commit at posedge clk. Latency is one cycle, and back-to-back RMW sees the prior write.
- mtvec and mepc writes force bits[1:0] to 0.
- Counters (64-bit, wrap to 0 after 2^64-1):
  - mcycle increments every cycle while reset=0.
  - minstret increments on instr_retire.
  - A CSR write to either half takes priority over the increment that cycle: the written half takes the written value, and the other half is left unchanged with no carry.
- Trap, when trap=1:
  - mepc <= trap_pc & ~3; mcause <= trap_cause; mtval <= trap_val.
  - MPIE <= MIE; MIE <= 0.
  - Any CSR write in the same cycle is dropped; counters still increment.
- mret=1: MIE <= MPIE; MPIE <= 1.
- trap and mret together: trap wins and mret is ignored.
- Reset:
  - All state is 0 except mtvec = MTVEC_RESET & ~3.
  - Outputs after reset: mtvec_o = MTVEC_RESET & ~3, mepc_o = 0, mie_o = 0.
  - Reset overrides trap, mret and writes in the same cycle.

Optional Feature:
- CSR_COUNTERS_EN defined: counter CSRs implemented as above.
- CSR_COUNTERS_EN undefined:
  - No counter flops are built.
  - Addresses 0xB00/0xB80/0xB02/0xB82/0xC00/0xC80/0xC02/0xC82 are unimplemented: they read 0 and are illegal on access.
  - instr_retire is ignored.

Test Plan:
- CSRRW mscratch from rs1_val=0xDEADBEEF, then CSRRS with rs1_val=0x0000000F: second rd_val=0xDEADBEEF; mscratch becomes 0xDEADBEEF (no change); then CSRRC with 0xF0000000 -> mscratch=0x0DEADBEEF&~0xF0000000=0x0EADBEEF.
- CSRRSI mhartid with zimm=0 -> illegal=0 and rd_val=HARTID; CSRRWI mhartid zimm=5 -> illegal=1, no change; access to 0x7C0 -> illegal=1, rd_val=0.
- Set MIE via CSRRSI 0x300 zimm=8, then trap with trap_pc=0x103, cause=2 -> mepc=0x100, mcause=2, mstatus=0x80, mie_o=0; then mret -> mstatus=0x88.
- Trap and CSRRW mscratch=0x55 in the same cycle -> mscratch unchanged, trap state updated; trap with mret in the same cycle -> MIE=0.
- (CSR_COUNTERS_EN) Write mcycle=0xFFFFFFFF, mcycleh=0 -> next cycles show carry into mcycleh=1; same-cycle write of minstret=7 with instr_retire=1 -> minstret=7, then 8 on the next retire.
- Assert reset mid-sequence after a trap -> mepc_o=0, mie_o=0, mtvec_o=MTVEC_RESET&~3, counters=0 the following cycle.
